// File: rtl/wave_pc_table.sv
// Per-SIMD wavefront PC table with round-robin issue selection.
// Optional feature macro: WAVE_PC_BRANCH_EN enables branch redirection on update.
module wave_pc_table #(
  parameter int PC_WIDTH      = 32,
  parameter int NUM_WAVES     = 4,
  parameter int WAVE_ID_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     dispatch_valid,
  input  logic [WAVE_ID_WIDTH-1:0] dispatch_wave_id,
  input  logic [PC_WIDTH-1:0]      dispatch_start_pc,
  output logic                     dispatch_ready,
  output logic                     issue_valid,
  output logic [WAVE_ID_WIDTH-1:0] issue_wave_id,
  output logic [PC_WIDTH-1:0]      issue_pc,
  input  logic                     issue_ready,
  input  logic                     update_valid,
  input  logic [WAVE_ID_WIDTH-1:0] update_wave_id,
  input  logic                     update_branch_taken,
  input  logic [PC_WIDTH-1:0]      update_branch_target,
  input  logic                     update_halt,
  output logic [NUM_WAVES-1:0]     wave_active,
  output logic                     all_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READY   = 2'd1,
    S_WAITING = 2'd2
  } state_t;

  state_t                     state [NUM_WAVES];
  logic [PC_WIDTH-1:0]        pc    [NUM_WAVES];
  logic [WAVE_ID_WIDTH-1:0]   rr_ptr;

  logic                       sel_found;
  logic [WAVE_ID_WIDTH-1:0]   sel_id;
  logic [WAVE_ID_WIDTH-1:0]   scan_id;

  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] p);
    return p + PC_WIDTH'(1);
  endfunction

`ifndef WAVE_PC_BRANCH_EN
  logic unused_branch;
  assign unused_branch = ^{update_branch_taken, update_branch_target};
`endif

  // Round-robin scan; slot index arithmetic wraps because NUM_WAVES is a power of two.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_id   = '0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      scan_id = rr_ptr + WAVE_ID_WIDTH'(i);
      if (!sel_found && state[scan_id] == S_READY) begin
        sel_found = 1'b1;
        sel_id    = scan_id;
      end
    end
  end

  assign issue_valid    = enable && sel_found;
  assign issue_wave_id  = issue_valid ? sel_id : '0;
  assign issue_pc       = issue_valid ? pc[sel_id] : '0;
  assign dispatch_ready = enable && (state[dispatch_wave_id] == S_IDLE);

  always_comb begin
    for (int i = 0; i < NUM_WAVES; i++) begin
      wave_active[i] = (state[i] != S_IDLE);
    end
  end

  assign all_done = ~|wave_active;

  // Dispatch, issue and update each act on a slot in a distinct state, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WAVES; i++) begin
        state[i] <= S_IDLE;
        pc[i]    <= '0;
      end
      rr_ptr <= '0;
    end else if (enable) begin
      if (dispatch_valid && state[dispatch_wave_id] == S_IDLE) begin
        state[dispatch_wave_id] <= S_READY;
        pc[dispatch_wave_id]    <= dispatch_start_pc;
      end
      if (issue_valid && issue_ready) begin
        state[sel_id] <= S_WAITING;
        rr_ptr        <= sel_id + WAVE_ID_WIDTH'(1);
      end
      if (update_valid && state[update_wave_id] == S_WAITING) begin
        if (update_halt) begin
          state[update_wave_id] <= S_IDLE;
          pc[update_wave_id]    <= '0;
`ifdef WAVE_PC_BRANCH_EN
        end else if (update_branch_taken) begin
          state[update_wave_id] <= S_READY;
          pc[update_wave_id]    <= update_branch_target;
`endif
        end else begin
          state[update_wave_id] <= S_READY;
          pc[update_wave_id]    <= pc_inc(pc[update_wave_id]);
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_pc_table.sv
// Directed self-checking bench for wave_pc_table (branch expectations follow WAVE_PC_BRANCH_EN).
module tb_wave_pc_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dispatch_valid;
  logic [1:0]  dispatch_wave_id;
  logic [31:0] dispatch_start_pc;
  logic        dispatch_ready;
  logic        issue_valid;
  logic [1:0]  issue_wave_id;
  logic [31:0] issue_pc;
  logic        issue_ready;
  logic        update_valid;
  logic [1:0]  update_wave_id;
  logic        update_branch_taken;
  logic [31:0] update_branch_target;
  logic        update_halt;
  logic [3:0]  wave_active;
  logic        all_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wave_pc_table #(.PC_WIDTH(32), .NUM_WAVES(4), .WAVE_ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .dispatch_valid(dispatch_valid), .dispatch_wave_id(dispatch_wave_id),
    .dispatch_start_pc(dispatch_start_pc), .dispatch_ready(dispatch_ready),
    .issue_valid(issue_valid), .issue_wave_id(issue_wave_id), .issue_pc(issue_pc),
    .issue_ready(issue_ready), .update_valid(update_valid), .update_wave_id(update_wave_id),
    .update_branch_taken(update_branch_taken), .update_branch_target(update_branch_target),
    .update_halt(update_halt), .wave_active(wave_active), .all_done(all_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [1:0] id, input logic [31:0] start);
    dispatch_valid = 1'b1; dispatch_wave_id = id; dispatch_start_pc = start;
    step();
    dispatch_valid = 1'b0; dispatch_wave_id = 2'd0;
  endtask

  task automatic update(input logic [1:0] id, input logic br, input logic [31:0] tgt, input logic halt);
    update_valid = 1'b1; update_wave_id = id; update_branch_taken = br;
    update_branch_target = tgt; update_halt = halt;
    step();
    update_valid = 1'b0; update_branch_taken = 1'b0; update_halt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL reset_all_done got=%b exp=1", all_done); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%b exp=0", issue_valid); end
    checks++; if (wave_active !== 4'b0000) begin failures++; $display("FAIL reset_wave_active got=%b exp=0000", wave_active); end
    checks++; if (issue_pc !== 32'h0) begin failures++; $display("FAIL reset_issue_pc got=%h exp=0", issue_pc); end
    checks++; if (dispatch_ready !== 1'b1) begin failures++; $display("FAIL reset_dispatch_ready got=%b exp=1", dispatch_ready); end
  endtask

  task automatic test_single_wave();
    do_reset();
    dispatch_valid = 1'b1; dispatch_wave_id = 2'd2; dispatch_start_pc = 32'h10;
    #1;
    checks++; if (dispatch_ready !== 1'b1) begin failures++; $display("FAIL single_dispatch_ready got=%b exp=1", dispatch_ready); end
    step();
    dispatch_valid = 1'b0;
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (issue_valid !== 1'b1 || issue_wave_id !== 2'd2) begin failures++; $display("FAIL single_issue k=%0d got=%b/%0d exp=1/2", k, issue_valid, issue_wave_id); end
      checks++; if (issue_pc !== 32'h10 + k) begin failures++; $display("FAIL single_pc k=%0d got=%h exp=%h", k, issue_pc, 32'h10 + k); end
      step();
      #1;
      checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL single_waiting k=%0d got=%b exp=0", k, issue_valid); end
      update(2'd2, 1'b0, 32'h0, 1'b0);
    end
    step();
    update(2'd2, 1'b0, 32'h0, 1'b1);
    issue_ready = 1'b0;
    #1;
    checks++; if (wave_active !== 4'b0000) begin failures++; $display("FAIL single_halt_active got=%b exp=0000", wave_active); end
    checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL single_halt_done got=%b exp=1", all_done); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_id [3];
    logic [31:0] exp_pc [3];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd3;
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h200; exp_pc[2] = 32'h300;
    do_reset();
    for (int k = 0; k < 3; k++) dispatch(exp_id[k], exp_pc[k]);
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (issue_valid !== 1'b1 || issue_wave_id !== exp_id[k] || issue_pc !== exp_pc[k]) begin
        failures++; $display("FAIL rr_order k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, issue_valid, issue_wave_id, issue_pc, exp_id[k], exp_pc[k]);
      end
      step();
    end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rr_drained got=%b exp=0", issue_valid); end
    issue_ready = 1'b0;
    update(2'd1, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_wave_id !== 2'd1 || issue_pc !== 32'h201) begin
      failures++; $display("FAIL rr_reissue got=%b/%0d/%h exp=1/1/00000201", issue_valid, issue_wave_id, issue_pc);
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc;
`ifdef WAVE_PC_BRANCH_EN
    exp_pc = 32'h40;
`else
    exp_pc = 32'h6;
`endif
    do_reset();
    dispatch(2'd0, 32'h5);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    update(2'd0, 1'b1, 32'h40, 1'b0);
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_pc !== exp_pc) begin failures++; $display("FAIL branch_pc got=%b/%h exp=1/%h", issue_valid, issue_pc, exp_pc); end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    update(2'd0, 1'b1, 32'h99, 1'b1);
    #1;
    checks++; if (wave_active !== 4'b0000 || issue_valid !== 1'b0) begin failures++; $display("FAIL branch_halt got=%b/%b exp=0000/0", wave_active, issue_valid); end
  endtask

  task automatic test_wrap_illegal();
    do_reset();
    dispatch(2'd1, 32'hFFFF_FFFF);
    update(2'd1, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (issue_pc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL upd_ready_ignored got=%h exp=ffffffff", issue_pc); end
    update(2'd2, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (wave_active !== 4'b0010) begin failures++; $display("FAIL upd_idle_ignored got=%b exp=0010", wave_active); end
    dispatch_valid = 1'b1; dispatch_wave_id = 2'd1; dispatch_start_pc = 32'h55;
    #1;
    checks++; if (dispatch_ready !== 1'b0) begin failures++; $display("FAIL dispatch_busy_ready got=%b exp=0", dispatch_ready); end
    step();
    dispatch_valid = 1'b0;
    #1;
    checks++; if (issue_pc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dispatch_busy_pc got=%h exp=ffffffff", issue_pc); end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    update(2'd1, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%b/%h exp=1/00000000", issue_valid, issue_pc); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    dispatch(2'd0, 32'hA0);
    dispatch(2'd1, 32'hB0);
    issue_ready = 1'b1;
    step(); step();
    issue_ready = 1'b0;
    enable = 1'b0;
    update_valid = 1'b1; update_wave_id = 2'd0;
    dispatch_valid = 1'b1; dispatch_wave_id = 2'd2; dispatch_start_pc = 32'h7;
    #1;
    checks++; if (dispatch_ready !== 1'b0 || issue_valid !== 1'b0) begin failures++; $display("FAIL en_off_outputs got=%b/%b exp=0/0", dispatch_ready, issue_valid); end
    step(); step(); step();
    enable = 1'b1; update_valid = 1'b0; dispatch_valid = 1'b0;
    #1;
    checks++; if (wave_active !== 4'b0011 || issue_valid !== 1'b0) begin failures++; $display("FAIL en_frozen got=%b/%b exp=0011/0", wave_active, issue_valid); end
    do_reset();
    #1;
    checks++; if (wave_active !== 4'b0000 || all_done !== 1'b1) begin failures++; $display("FAIL reset_midrun got=%b/%b exp=0000/1", wave_active, all_done); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1;
    dispatch_valid = 1'b0; dispatch_wave_id = 2'd0; dispatch_start_pc = 32'h0;
    issue_ready = 1'b0;
    update_valid = 1'b0; update_wave_id = 2'd0; update_branch_taken = 1'b0;
    update_branch_target = 32'h0; update_halt = 1'b0;
    test_reset();
    test_single_wave();
    test_round_robin();
    test_branch();
    test_wrap_illegal();
    test_enable_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
